// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for a 2-digit sign-magnitude BCD ALU.
// Collects operands/operators from key strobes, runs the ALU for ALU_HOLD
// cycles and captures the result as the next left operand.
module calc_sequencer #(
    parameter int ALU_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic       key_ready,
    input  logic [8:0] alu_result,
    output logic [8:0] alu_op1,
    output logic [8:0] alu_op2,
    output logic [2:0] alu_opcode,
    output logic       alu_en,
    output logic [8:0] disp_val,
    output logic       err,
    output logic       busy
);
    localparam int HW = (ALU_HOLD > 1) ? $clog2(ALU_HOLD) : 1;

    typedef enum logic [2:0] {S_OP1, S_OP2, S_EXEC, S_RES, S_ERR} state_t;

    state_t          state_q, state_d;
    logic [8:0]      op1_q, op1_d, op2_q, op2_d, disp_hold_q;
    logic [2:0]      opcode_q, opcode_d, chain_op_q, chain_op_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            chain_vld_q, chain_vld_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic       acc, is_dig, is_op, is_eq, is_clr, is_neg;
    logic       div0, hold_last, has_dig;
    logic [2:0] key_op;
    logic [8:0] res_n;

    assign acc       = key_valid & key_ready;
    assign is_dig    = key_code < 5'd10;
    assign is_op     = (key_code >= 5'd10) && (key_code <= 5'd13);
    assign is_eq     = key_code == 5'd14;
    assign is_clr    = key_code == 5'd15;
    assign is_neg    = key_code == 5'd16;
    assign key_op    = 3'(key_code - 5'd9);
    assign has_dig   = cnt_q != 2'd0;
    // Only an actual execution attempt can trip divide-by-zero; an operator
    // with no op2 digits just changes its mind about the opcode.
    assign div0      = (opcode_q == 3'b100) && (op2_q[7:0] == 8'd0);
    assign hold_last = hold_q == HW'(ALU_HOLD - 1);
    // A signed zero from the ALU is shown as plain zero.
    assign res_n     = (alu_result == 9'h100) ? 9'h000 : alu_result;

    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_opcode = opcode_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_OP1;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (acc && is_clr) state_d = S_OP1;
        else begin
            case (state_q)
                S_OP1:  if (acc && is_op) state_d = S_OP2;
                S_OP2:  if (acc && (is_eq || is_op) && has_dig)
                            state_d = div0 ? S_ERR : S_EXEC;
                S_EXEC: if (hold_last) state_d = chain_vld_q ? S_OP2 : S_RES;
                S_RES:  if (acc && is_dig)     state_d = S_OP1;
                        else if (acc && is_op) state_d = S_OP2;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from state; EXEC freezes the display on its last value
    always_comb begin
        key_ready = state_q != S_EXEC;
        alu_en    = state_q == S_EXEC;
        busy      = state_q == S_EXEC;
        err       = state_q == S_ERR;
        case (state_q)
            S_OP2:   disp_val = has_dig ? op2_q : op1_q;
            S_EXEC:  disp_val = disp_hold_q;
            S_ERR:   disp_val = 9'h000;
            default: disp_val = op1_q;
        endcase
    end

    // Operand / opcode / digit-count / chain datapath next values
    always_comb begin
        op1_d       = op1_q;
        op2_d       = op2_q;
        opcode_d    = opcode_q;
        cnt_d       = cnt_q;
        chain_vld_d = chain_vld_q;
        chain_op_d  = chain_op_q;
        hold_d      = '0;
        if (acc && is_clr) begin
            op1_d       = 9'h000;
            op2_d       = 9'h000;
            opcode_d    = 3'b001;
            cnt_d       = 2'd0;
            chain_vld_d = 1'b0;
            chain_op_d  = 3'b001;
        end else begin
            case (state_q)
                S_OP1: if (acc) begin
                    if (is_dig && cnt_q < 2'd2) begin
                        op1_d = {op1_q[8], op1_q[3:0], key_code[3:0]};
                        cnt_d = cnt_q + 2'd1;
                    end else if (is_neg) op1_d[8] = ~op1_q[8];
                    else if (is_op) begin
                        opcode_d = key_op;
                        op2_d    = 9'h000;
                        cnt_d    = 2'd0;
                    end
                end
                S_OP2: if (acc) begin
                    if (is_dig && cnt_q < 2'd2) begin
                        op2_d = {op2_q[8], op2_q[3:0], key_code[3:0]};
                        cnt_d = cnt_q + 2'd1;
                    end else if (is_neg) op2_d[8] = ~op2_q[8];
                    else if (is_op && !has_dig) opcode_d = key_op;
                    else if (is_op && !div0) begin
                        chain_vld_d = 1'b1;
                        chain_op_d  = key_op;
                    end
                end
                S_EXEC: begin
                    hold_d = hold_last ? '0 : hold_q + HW'(1);
                    if (hold_last) begin
                        op1_d = res_n;
                        cnt_d = 2'd0;
                        if (chain_vld_q) begin
                            opcode_d    = chain_op_q;
                            op2_d       = 9'h000;
                            chain_vld_d = 1'b0;
                        end
                    end
                end
                S_RES: if (acc) begin
                    if (is_dig) begin
                        op1_d = {5'd0, key_code[3:0]};
                        cnt_d = 2'd1;
                    end else if (is_neg) op1_d[8] = ~op1_q[8];
                    else if (is_op) begin
                        opcode_d = key_op;
                        op2_d    = 9'h000;
                        cnt_d    = 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q       <= 9'h000;
            op2_q       <= 9'h000;
            opcode_q    <= 3'b001;
            cnt_q       <= 2'd0;
            chain_vld_q <= 1'b0;
            chain_op_q  <= 3'b001;
            hold_q      <= '0;
            disp_hold_q <= 9'h000;
        end else begin
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opcode_q    <= opcode_d;
            cnt_q       <= cnt_d;
            chain_vld_q <= chain_vld_d;
            chain_op_q  <= chain_op_d;
            hold_q      <= hold_d;
            disp_hold_q <= disp_val;
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: two instances (ALU_HOLD=1 and 3) fed the same
// keys, with a behavioural ALU and a key-level calculator model.
module tb_calc_sequencer;
    logic       clk = 1'b0;
    logic       rst, key_valid;
    logic [4:0] key_code;
    logic       kr_a, en_a, err_a, busy_a, kr_b, en_b, err_b, busy_b;
    logic [8:0] res_a, op1_a, op2_a, disp_a, res_b, op1_b, op2_b, disp_b;
    logic [2:0] opc_a, opc_b;
    logic       stub_en = 1'b0;
    logic [8:0] stub_val = 9'h000;
    int         checks = 0, failures = 0, en_cnt_a = 0;

    // model state: ms 0=entering op1, 1=op2, 2=result, 3=error
    int ms, m1m, m2m, mop, mcnt;
    bit m1s, m2s;

    always #5 clk = ~clk;

    calc_sequencer #(.ALU_HOLD(1)) dut_a (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(kr_a), .alu_result(res_a), .alu_op1(op1_a), .alu_op2(op2_a),
        .alu_opcode(opc_a), .alu_en(en_a), .disp_val(disp_a), .err(err_a), .busy(busy_a));

    calc_sequencer #(.ALU_HOLD(3)) dut_b (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(kr_b), .alu_result(res_b), .alu_op1(op1_b), .alu_op2(op2_b),
        .alu_opcode(opc_b), .alu_en(en_b), .disp_val(disp_b), .err(err_b), .busy(busy_b));

    function automatic logic [8:0] pk(input bit s, input int m);
        return {s, 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [8:0] alu_f(input logic [8:0] a, input logic [8:0] b, input logic [2:0] op);
        int va, vb, r, m;
        va = int'(a[7:4]) * 10 + int'(a[3:0]); if (a[8]) va = -va;
        vb = int'(b[7:4]) * 10 + int'(b[3:0]); if (b[8]) vb = -vb;
        case (op)
            3'd1: r = va + vb;
            3'd2: r = va - vb;
            3'd3: r = va * vb;
            3'd4: r = (vb == 0) ? 0 : va / vb;
            default: r = 0;
        endcase
        m = (r < 0) ? -r : r;
        m = m % 100;
        return pk(r < 0, m);
    endfunction

    always_comb res_a = stub_en ? stub_val : alu_f(op1_a, op2_a, opc_a);
    always_comb res_b = stub_en ? stub_val : alu_f(op1_b, op2_b, opc_b);

    always @(posedge clk) if (en_a) en_cnt_a <= en_cnt_a + 1;

    task automatic m_reset();
        ms = 0; m1s = 0; m1m = 0; m2s = 0; m2m = 0; mop = 1; mcnt = 0;
    endtask

    task automatic m_exec(input int chain);
        logic [8:0] r;
        r = stub_en ? stub_val : alu_f(pk(m1s, m1m), pk(m2s, m2m), 3'(mop));
        if (r == 9'h100) r = 9'h000;
        m1s = r[8]; m1m = int'(r[7:4]) * 10 + int'(r[3:0]); mcnt = 0;
        if (chain != 0) begin mop = chain; m2s = 0; m2m = 0; ms = 1; end
        else ms = 2;
    endtask

    task automatic m_key(input int k);
        bit dig, op;
        dig = k < 10; op = k >= 10 && k <= 13;
        if (k == 15) begin m_reset(); return; end
        case (ms)
            0: if (dig && mcnt < 2) begin m1m = (m1m % 10) * 10 + k; mcnt++; end
               else if (k == 16) m1s = ~m1s;
               else if (op) begin mop = k - 9; m2s = 0; m2m = 0; mcnt = 0; ms = 1; end
            1: if (dig && mcnt < 2) begin m2m = (m2m % 10) * 10 + k; mcnt++; end
               else if (k == 16) m2s = ~m2s;
               else if ((op || k == 14) && mcnt > 0) begin
                   if (mop == 4 && m2m == 0) ms = 3;
                   else m_exec(op ? k - 9 : 0);
               end else if (op) mop = k - 9;
            2: if (dig) begin m1s = 0; m1m = k; mcnt = 1; ms = 0; end
               else if (k == 16) m1s = ~m1s;
               else if (op) begin mop = k - 9; m2s = 0; m2m = 0; mcnt = 0; ms = 1; end
            default: ;
        endcase
    endtask

    function automatic logic [8:0] exp_disp();
        case (ms)
            1: return (mcnt > 0) ? pk(m2s, m2m) : pk(m1s, m1m);
            3: return 9'h000;
            default: return pk(m1s, m1m);
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin checks++; failures++; $display("FAIL idle_timeout busy_a=%b busy_b=%b", busy_a, busy_b); end
    endtask

    // strobe one key without waiting for EXEC to finish
    task automatic strobe(input int k);
        int n = 0;
        while (!(kr_a && kr_b) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin checks++; failures++; $display("FAIL ready_timeout kr_a=%b kr_b=%b", kr_a, kr_b); end
        key_valid = 1'b1; key_code = 5'(k);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press(input int k);
        strobe(k); wait_idle(); m_key(k);
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0; m_reset();
        checks++; if (kr_a !== 1'b1)     begin failures++; $display("FAIL rst_key_ready got=%b exp=1", kr_a); end
        checks++; if (en_a !== 1'b0)     begin failures++; $display("FAIL rst_alu_en got=%b exp=0", en_a); end
        checks++; if ({err_a, busy_a} !== 2'b00) begin failures++; $display("FAIL rst_err_busy got=%b exp=00", {err_a, busy_a}); end
        checks++; if (disp_a !== 9'h000) begin failures++; $display("FAIL rst_disp got=%h exp=000", disp_a); end
        checks++; if ({op1_a, op2_a, opc_a} !== {9'h000, 9'h000, 3'b001}) begin failures++; $display("FAIL rst_regs got=%h/%h/%b exp=000/000/001", op1_a, op2_a, opc_a); end
    endtask

    task automatic test_basic_latency();
        int seq[5] = '{1, 2, 10, 3, 4};
        press(15);
        foreach (seq[i]) press(seq[i]);
        strobe(14);
        checks++; if (en_a !== 1'b1) begin failures++; $display("FAIL lat_en_n1 got=%b exp=1", en_a); end
        checks++; if ({op1_a, op2_a, opc_a} !== {9'h012, 9'h034, 3'b001}) begin failures++; $display("FAIL lat_ops got=%h/%h/%b exp=012/034/001", op1_a, op2_a, opc_a); end
        checks++; if (kr_a !== 1'b0 || disp_a !== 9'h034) begin failures++; $display("FAIL lat_exec_hold got kr=%b disp=%h exp kr=0 disp=034", kr_a, disp_a); end
        @(negedge clk);
        checks++; if (en_a !== 1'b0) begin failures++; $display("FAIL lat_en_n2 got=%b exp=0", en_a); end
        checks++; if (disp_a !== 9'h046) begin failures++; $display("FAIL lat_disp got=%h exp=046", disp_a); end
        wait_idle(); m_key(14);
    endtask

    task automatic test_digit_limit();
        press(15); press(1); press(2); press(3);
        checks++; if (op1_a !== 9'h012) begin failures++; $display("FAIL third_digit got=%h exp=012", op1_a); end
        press(16);
        checks++; if (op1_a !== 9'h112 || disp_a !== 9'h112) begin failures++; $display("FAIL neg_op1 got=%h/%h exp=112", op1_a, disp_a); end
    endtask

    task automatic test_div0();
        int c0;
        press(15); press(5); press(13); press(0);
        c0 = en_cnt_a;
        press(14);
        checks++; if (err_a !== 1'b1 || disp_a !== 9'h000) begin failures++; $display("FAIL div0_err got err=%b disp=%h exp err=1 disp=000", err_a, disp_a); end
        press(7); press(16);
        checks++; if (err_a !== 1'b1 || disp_a !== 9'h000 || kr_a !== 1'b1) begin failures++; $display("FAIL div0_ignore got err=%b disp=%h", err_a, disp_a); end
        checks++; if (en_cnt_a !== c0) begin failures++; $display("FAIL div0_no_en got=%0d exp=%0d", en_cnt_a, c0); end
        press(15);
        checks++; if (err_a !== 1'b0 || op1_a !== 9'h000 || disp_a !== 9'h000) begin failures++; $display("FAIL div0_clear got err=%b op1=%h", err_a, op1_a); end
    endtask

    task automatic test_chain();
        press(15); press(9); press(12); press(3); press(10);
        checks++; if ({op1_a, op2_a, opc_a} !== {9'h027, 9'h000, 3'b001}) begin failures++; $display("FAIL chain_first got=%h/%h/%b exp=027/000/001", op1_a, op2_a, opc_a); end
        checks++; if (disp_a !== 9'h027) begin failures++; $display("FAIL chain_disp1 got=%h exp=027", disp_a); end
        press(4);
        checks++; if ({op1_a, op2_a} !== {9'h027, 9'h004}) begin failures++; $display("FAIL chain_ops2 got=%h/%h exp=027/004", op1_a, op2_a); end
        press(14);
        checks++; if (disp_a !== 9'h031 || disp_b !== 9'h031) begin failures++; $display("FAIL chain_result got=%h/%h exp=031", disp_a, disp_b); end
    endtask

    task automatic test_hold3();
        int n = 0; bit kr_bad = 0;
        press(15); press(2); press(10); press(3);
        strobe(14);
        while (en_b && n < 10) begin if (kr_b) kr_bad = 1; n++; @(negedge clk); end
        wait_idle(); m_key(14);
        checks++; if (n !== 3) begin failures++; $display("FAIL hold3_len got=%0d exp=3", n); end
        checks++; if (kr_bad) begin failures++; $display("FAIL hold3_ready got=1 exp=0"); end
        checks++; if (disp_b !== 9'h005) begin failures++; $display("FAIL hold3_disp got=%h exp=005", disp_b); end
        press(15); press(4); press(10); press(5);
        strobe(14);
        @(negedge clk);
        checks++; if (en_b !== 1'b1) begin failures++; $display("FAIL hold3_cyc2 got=%b exp=1", en_b); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_reset();
        checks++; if ({en_b, busy_b, err_b, kr_b} !== 4'b0001) begin failures++; $display("FAIL hold3_rst_ctl got=%b exp=0001", {en_b, busy_b, err_b, kr_b}); end
        checks++; if ({op1_b, op2_b, opc_b, disp_b} !== {9'h000, 9'h000, 3'b001, 9'h000}) begin failures++; $display("FAIL hold3_rst_regs got=%h/%h/%b/%h", op1_b, op2_b, opc_b, disp_b); end
    endtask

    task automatic test_neg_zero();
        int seq[5] = '{15, 3, 11, 5, 14};
        stub_en = 1'b1; stub_val = 9'h100;
        foreach (seq[i]) press(seq[i]);
        checks++; if (disp_a !== 9'h000 || disp_b !== 9'h000) begin failures++; $display("FAIL negzero got=%h/%h exp=000", disp_a, disp_b); end
        stub_val = 9'h102;
        foreach (seq[i]) press(seq[i]);
        checks++; if (disp_a !== 9'h102) begin failures++; $display("FAIL neg2 got=%h exp=102", disp_a); end
        stub_en = 1'b0;
        press(15);
    endtask

    task automatic test_random();
        int r, k;
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 58)      k = r % 10;
            else if (r < 74) k = 10 + r % 4;
            else if (r < 84) k = 14;
            else if (r < 91) k = 16;
            else if (r < 96) k = 15;
            else             k = 17 + r % 15;
            press(k);
            checks++; if (disp_a !== exp_disp()) begin failures++; $display("FAIL rand_disp_a key=%0d got=%h exp=%h", k, disp_a, exp_disp()); end
            checks++; if (disp_b !== exp_disp()) begin failures++; $display("FAIL rand_disp_b key=%0d got=%h exp=%h", k, disp_b, exp_disp()); end
            checks++; if (err_a !== (ms == 3)) begin failures++; $display("FAIL rand_err key=%0d got=%b exp=%b", k, err_a, ms == 3); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_latency();
        test_digit_limit();
        test_div0();
        test_chain();
        test_hold3();
        test_neg_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
